// File: rtl/mult_share_pkg.sv
// -----------------------------------------------------------------------------
// mult_share_pkg
// Shared types and constants for the multiplier-sharing controller.
//   - state_e      : sequencer states
//   - DEF_MBITS/NBITS : default operand widths of the shared Booth multiplier
//   - TIMEOUT_CYC  : WAIT_DONE cycle budget for the default multiplier width
//   - clog2()      : elaboration-time ceil(log2), minimum 1
// -----------------------------------------------------------------------------
package mult_share_pkg;

  localparam int DEF_MBITS = 16;
  localparam int DEF_NBITS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // A healthy multiply finishes in about NBITS cycles; the extra 8 cycles
  // give margin before declaring the multiplier stuck.
  function automatic int timeout_cyc(input int nbits);
    return nbits + 8;
  endfunction

  localparam int TIMEOUT_CYC = timeout_cyc(DEF_NBITS);

endpackage

// File: rtl/mult_rr_pick.sv
// -----------------------------------------------------------------------------
// mult_rr_pick
// Combinational round-robin picker. Searches req starting one above ptr and
// wrapping around, so the requester granted last has the lowest priority.
// Ports:
//   req         in  NREQ  pending requests
//   ptr         in  IDW   index granted last time
//   grant_valid out 1     some request is pending
//   grant_id    out IDW   index of the winning request
// -----------------------------------------------------------------------------
module mult_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // the last hit written is therefore the highest-priority one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
// Shares one sequential signed Booth multiplier among NREQ requesters.
// Grants round-robin, registers the winner's operands and holds them for the
// whole multiply, pulses start, waits for busy to fall and returns the upper
// product half tagged with the requester id.
// Optional feature: define MULT_SHARE_TIMEOUT_EN to abort a multiply whose
// busy flag stays high too long (result forced to 0, err pulsed).
// Ports:
//   wClk, rst            clock, synchronous active-high reset
//   req                  per-requester request, held until ack
//   mpd_flat, mpr_flat   packed operands, slice i belongs to req[i]
//   ack                  one-cycle pulse: operands of requester i captured
//   result_valid         one-cycle pulse: result belongs to requester i
//   result, result_id    last product (upper half) and its requester id
//   mult_start/xMpd/mpr  registered drive to the multiplier
//   mult_busy, mult_prod status/product from the multiplier
//   idle                 high while in IDLE
//   err                  timeout pulse (constant 0 without the feature)
// -----------------------------------------------------------------------------
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int MBITS = DEF_MBITS,
  parameter int NBITS = DEF_NBITS,
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  wClk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MBITS-1:0] mpd_flat,
  input  logic [NREQ*NBITS-1:0] mpr_flat,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       result_valid,
  output logic [MBITS-1:0]      result,
  output logic [IDW-1:0]        result_id,
  output logic                  mult_start,
  output logic [MBITS-1:0]      mult_xMpd,
  output logic [NBITS-1:0]      mult_mpr,
  input  logic                  mult_busy,
  input  logic [MBITS-1:0]      mult_prod,
  output logic                  idle,
  output logic                  err
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [MBITS-1:0]  result_q, result_d;
  logic [IDW-1:0]    rid_q, rid_d;
  logic              start_q, start_d;
  logic [MBITS-1:0]  xmpd_q, xmpd_d;
  logic [NBITS-1:0]  mpr_q, mpr_d;
  logic              idle_q, idle_d;

  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int TO_CYC = timeout_cyc(NBITS);
  localparam int CW     = clog2(TO_CYC);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  mult_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req         (req),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    rvalid_d = '0;
    start_d  = 1'b0;
    result_d = result_q;
    rid_d    = rid_q;
    xmpd_d   = xmpd_q;
    mpr_d    = mpr_q;
`ifdef MULT_SHARE_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = 1'b0;
`endif
    // ptr_q doubles as the id of the in-flight requester from grant to result.
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          xmpd_d         = mpd_flat[grant_id*MBITS +: MBITS];
          mpr_d          = mpr_flat[grant_id*NBITS +: NBITS];
          ptr_d          = grant_id;
          ack_d[grant_id] = 1'b1;
          start_d        = 1'b1;
          state_d        = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      // busy is not yet trustworthy here; the multiplier raises it this cycle.
      WAIT_BUSY: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!mult_busy) begin
          result_d        = mult_prod;
          rid_d           = ptr_q;
          rvalid_d[ptr_q] = 1'b1;
          state_d         = IDLE;
        end
`ifdef MULT_SHARE_TIMEOUT_EN
        else if (cnt_q == CW'(TO_CYC - 1)) begin
          result_d        = '0;
          rid_d           = ptr_q;
          rvalid_d[ptr_q] = 1'b1;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge wClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDW'(NREQ - 1);
      ack_q    <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      rid_q    <= '0;
      start_q  <= 1'b0;
      xmpd_q   <= '0;
      mpr_q    <= '0;
      idle_q   <= 1'b1;
`ifdef MULT_SHARE_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      rid_q    <= rid_d;
      start_q  <= start_d;
      xmpd_q   <= xmpd_d;
      mpr_q    <= mpr_d;
      idle_q   <= idle_d;
`ifdef MULT_SHARE_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ack          = ack_q;
  assign result_valid = rvalid_q;
  assign result       = result_q;
  assign result_id    = rid_q;
  assign mult_start   = start_q;
  assign mult_xMpd    = xmpd_q;
  assign mult_mpr     = mpr_q;
  assign idle         = idle_q;
`ifdef MULT_SHARE_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_share_ctrl
// Directed bench for mult_share_ctrl with a behavioural stand-in for the
// shared multiplier: busy rises the cycle after start, stays high for NBITS+1
// cycles, and the upper product half is computed from the live operand
// registers when busy falls. Expected products are hand-computed constants.
// Honours MULT_SHARE_TIMEOUT_EN for the stuck-busy scenario.
// -----------------------------------------------------------------------------
module tb_mult_share_ctrl;

  localparam int NREQ  = 4;
  localparam int MBITS = 16;
  localparam int NBITS = 16;
  localparam int IDW   = 2;

  logic                  wClk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [MBITS-1:0]      mpd [NREQ];
  logic [NBITS-1:0]      mpr [NREQ];
  logic [NREQ*MBITS-1:0] mpd_flat;
  logic [NREQ*NBITS-1:0] mpr_flat;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       result_valid;
  logic [MBITS-1:0]      result;
  logic [IDW-1:0]        result_id;
  logic                  mult_start;
  logic [MBITS-1:0]      mult_xMpd;
  logic [NBITS-1:0]      mult_mpr;
  logic                  mult_busy;
  logic [MBITS-1:0]      mult_prod;
  logic                  idle;
  logic                  err;

  int asserts  = 0;
  int failures = 0;
  int cyc      = 0;

  assign mpd_flat = {mpd[3], mpd[2], mpd[1], mpd[0]};
  assign mpr_flat = {mpr[3], mpr[2], mpr[1], mpr[0]};

  mult_share_ctrl #(
    .NREQ (NREQ), .MBITS (MBITS), .NBITS (NBITS), .IDW (IDW)
  ) dut (
    .wClk         (wClk),
    .rst          (rst),
    .req          (req),
    .mpd_flat     (mpd_flat),
    .mpr_flat     (mpr_flat),
    .ack          (ack),
    .result_valid (result_valid),
    .result       (result),
    .result_id    (result_id),
    .mult_start   (mult_start),
    .mult_xMpd    (mult_xMpd),
    .mult_mpr     (mult_mpr),
    .mult_busy    (mult_busy),
    .mult_prod    (mult_prod),
    .idle         (idle),
    .err          (err)
  );

  initial wClk = 1'b0;
  always #5 wClk = ~wClk;

  // ---------------- multiplier stand-in ----------------
  logic       m_busy = 1'b0;
  logic [4:0] m_cnt  = '0;
  logic       stuck  = 1'b0;
  logic [MBITS-1:0] m_prod = '0;

  function automatic logic [15:0] upper_prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[31:16];
  endfunction

  always @(posedge wClk) begin
    if (mult_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 5'(NBITS);
    end else if (m_busy && !stuck) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_prod <= upper_prod(mult_xMpd, mult_mpr);
      end else begin
        m_cnt <= m_cnt - 1'b1;
      end
    end
  end

  assign mult_busy = m_busy | stuck;
  assign mult_prod = m_prod;

  // ---------------- helpers (stimulus / timing only) ----------------
  task automatic tick();
    @(posedge wClk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input int limit);
    int n;
    n = 0;
    do begin tick(); n++; end while (ack == '0 && n < limit);
  endtask

  task automatic wait_rv(input int limit);
    int n;
    n = 0;
    do begin tick(); n++; end while (result_valid == '0 && n < limit);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin mpd[i] = '0; mpr[i] = '0; end
    tick(); tick(); tick();
    asserts++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
    asserts++; if (result_valid !== 4'b0) begin failures++; $display("FAIL reset_rv: got %b want 0000", result_valid); end
    asserts++; if (result !== 16'h0) begin failures++; $display("FAIL reset_result: got %h want 0000", result); end
    asserts++; if (result_id !== 2'd0) begin failures++; $display("FAIL reset_rid: got %0d want 0", result_id); end
    asserts++; if (mult_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", mult_start); end
    asserts++; if (mult_xMpd !== 16'h0 || mult_mpr !== 16'h0) begin failures++; $display("FAIL reset_operands: got %h/%h want 0000/0000", mult_xMpd, mult_mpr); end
    asserts++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b want 1", idle); end
    asserts++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    tick();
    asserts++; if (idle !== 1'b1 || ack !== 4'b0) begin failures++; $display("FAIL reset_quiet: got idle=%b ack=%b want 1/0000", idle, ack); end
  endtask

  // One isolated transaction on requester id; full latency and value checks.
  task automatic run_single(input string tag, input int id, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] exp);
    int t;
    mpd[id] = a;
    mpr[id] = b;
    req     = 4'(1 << id);
    t       = cyc;
    tick();
    asserts++; if (ack !== 4'(1 << id)) begin failures++; $display("FAIL %s_ack: got %b want %b", tag, ack, 4'(1 << id)); end
    asserts++; if (mult_start !== 1'b1) begin failures++; $display("FAIL %s_start: got %b want 1", tag, mult_start); end
    asserts++; if (mult_xMpd !== a || mult_mpr !== b) begin failures++; $display("FAIL %s_operands: got %h/%h want %h/%h", tag, mult_xMpd, mult_mpr, a, b); end
    req = '0;
    tick();
    asserts++; if (mult_start !== 1'b0 || ack !== 4'b0) begin failures++; $display("FAIL %s_pulse: got start=%b ack=%b want 0/0000", tag, mult_start, ack); end
    wait_rv(40);
    asserts++; if (cyc - t !== NBITS + 4) begin failures++; $display("FAIL %s_latency: got %0d want %0d", tag, cyc - t, NBITS + 4); end
    asserts++; if (result_valid !== 4'(1 << id)) begin failures++; $display("FAIL %s_rv: got %b want %b", tag, result_valid, 4'(1 << id)); end
    asserts++; if (result !== exp) begin failures++; $display("FAIL %s_result: got %h want %h", tag, result, exp); end
    asserts++; if (result_id !== 2'(id)) begin failures++; $display("FAIL %s_rid: got %0d want %0d", tag, result_id, id); end
    asserts++; if (idle !== 1'b1) begin failures++; $display("FAIL %s_idle: got %b want 1", tag, idle); end
    tick();
    asserts++; if (result_valid !== 4'b0 || result !== exp) begin failures++; $display("FAIL %s_hold: got rv=%b result=%h want 0000/%h", tag, result_valid, result, exp); end
  endtask

  task automatic test_single();
    run_single("single", 0, 16'h4000, 16'h4000, 16'h1000);
  endtask

  task automatic test_signed();
    run_single("signed", 2, 16'hC000, 16'h4000, 16'hF000);
  endtask

  task automatic test_back_to_back();
    int ord  [5] = '{0, 1, 2, 3, 0};
    logic [15:0] prod [5] = '{16'h0020, 16'h0040, 16'hFFFC, 16'h3FFF, 16'h0020};
    int t0, last;
    do_reset();
    mpd[0] = 16'h2000; mpr[0] = 16'h0100;
    mpd[1] = 16'h0800; mpr[1] = 16'h0800;
    mpd[2] = 16'hFF00; mpr[2] = 16'h0400;
    mpd[3] = 16'h7FFF; mpr[3] = 16'h7FFF;
    req  = 4'hF;
    t0   = cyc;
    last = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40);
      asserts++; if (ack !== 4'(1 << ord[k])) begin failures++; $display("FAIL b2b_grant%0d: got %b want %b", k, ack, 4'(1 << ord[k])); end
      if (k == 0) begin
        asserts++; if (cyc - t0 !== 1) begin failures++; $display("FAIL b2b_first_ack: got %0d want 1", cyc - t0); end
      end else begin
        asserts++; if (cyc - last !== NBITS + 4) begin failures++; $display("FAIL b2b_period%0d: got %0d want %0d", k, cyc - last, NBITS + 4); end
      end
      last = cyc;
      if (k == 4) req = '0;
      wait_rv(40);
      asserts++; if (result_valid !== 4'(1 << ord[k]) || result_id !== 2'(ord[k])) begin failures++; $display("FAIL b2b_rv%0d: got %b id %0d want %b id %0d", k, result_valid, result_id, 4'(1 << ord[k]), ord[k]); end
      asserts++; if (result !== prod[k]) begin failures++; $display("FAIL b2b_result%0d: got %h want %h", k, result, prod[k]); end
    end
    tick(); tick();
    asserts++; if (ack !== 4'b0 || idle !== 1'b1) begin failures++; $display("FAIL b2b_stop: got ack=%b idle=%b want 0000/1", ack, idle); end
  endtask

  task automatic test_capture();
    logic bad;
    int   n;
    mpd[1] = 16'h1234;
    mpr[1] = 16'h0200;
    req    = 4'b0010;
    wait_ack(40);
    asserts++; if (ack !== 4'b0010) begin failures++; $display("FAIL capture_ack: got %b want 0010", ack); end
    req    = '0;
    mpd[1] = 16'h7FFF;
    mpr[1] = 16'h7FFF;
    bad    = 1'b0;
    n      = 0;
    do begin
      tick(); n++;
      if (mult_xMpd !== 16'h1234 || mult_mpr !== 16'h0200) bad = 1'b1;
    end while (result_valid == '0 && n < 40);
    asserts++; if (bad !== 1'b0) begin failures++; $display("FAIL capture_stable: got unstable=%b want 0", bad); end
    asserts++; if (result !== 16'h0024 || result_id !== 2'd1) begin failures++; $display("FAIL capture_result: got %h id %0d want 0024 id 1", result, result_id); end
  endtask

  task automatic test_drop();
    logic seen;
    mpd[0] = 16'h4000;
    mpr[0] = 16'h4000;
    req    = 4'b0001;
    wait_ack(40);
    req = '0;
    for (int i = 0; i < 5; i++) tick();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    req = '0;
    wait_rv(40);
    asserts++; if (result !== 16'h1000 || result_valid !== 4'b0001) begin failures++; $display("FAIL drop_result: got %h rv %b want 1000 rv 0001", result, result_valid); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (ack != '0 || mult_start) seen = 1'b1; end
    asserts++; if (seen !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL drop_nogrant: got grant=%b idle=%b want 0/1", seen, idle); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    mpd[3] = 16'h5555;
    mpr[3] = 16'h1111;
    req    = 4'b1000;
    wait_ack(40);
    req = '0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++; if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle: got %b want 1", idle); end
    asserts++; if (result_valid !== 4'b0 || result !== 16'h0 || result_id !== 2'd0) begin failures++; $display("FAIL rstmid_clear: got rv=%b result=%h id=%0d want 0000/0000/0", result_valid, result, result_id); end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (result_valid != '0 || ack != '0) seen = 1'b1; end
    asserts++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_dropped: got activity=%b want 0", seen); end
    run_single("rstmid", 3, 16'h6000, 16'h2000, 16'h0C00);
  endtask

  task automatic test_timeout();
    int a;
    do_reset();
    stuck  = 1'b1;
    mpd[0] = 16'h4000;
    mpr[0] = 16'h4000;
    req    = 4'b0001;
    wait_ack(40);
    a   = cyc;
    req = '0;
`ifdef MULT_SHARE_TIMEOUT_EN
    wait_rv(60);
    asserts++; if (cyc - a !== NBITS + 10) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", cyc - a, NBITS + 10); end
    asserts++; if (err !== 1'b1 || result_valid !== 4'b0001) begin failures++; $display("FAIL timeout_pulse: got err=%b rv=%b want 1/0001", err, result_valid); end
    asserts++; if (result !== 16'h0 || result_id !== 2'd0) begin failures++; $display("FAIL timeout_result: got %h id %0d want 0000 id 0", result, result_id); end
    tick();
    asserts++; if (err !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL timeout_after: got err=%b idle=%b want 0/1", err, idle); end
`else
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (result_valid != '0 || err || idle) seen = 1'b1;
      end
      asserts++; if (seen !== 1'b0) begin failures++; $display("FAIL timeout_hang: got activity=%b want 0", seen); end
      asserts++; if (idle !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL timeout_state: got idle=%b err=%b want 0/0", idle, err); end
    end
`endif
    stuck = 1'b0;
    do_reset();
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_capture();
    test_drop();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
